// File: rtl/bsg_rr_arb_mux_buffer_w28_e2_if.sv
// ---------------------------------------------------------------------------
// bsg_rr_arb_mux_buffer_w28_e2_if
// Handshake bundle for the two-channel round-robin arbiter / output buffer.
//   data_i        : {ch1, ch0} producer payloads, width_p bits each
//   v_i           : per-channel producer valid
//   yumi_o        : per-channel accept back to the producers (one-hot or zero)
//   sel_one_hot_o : raw grant vector, ungated by FIFO full (debug tap)
//   data_o/tag_o  : FIFO head payload and its source channel
//   v_o           : FIFO non-empty
//   yumi_i        : downstream consumes the head
// The "slave" modport is the buffer's view; "master" is the environment's.
// ---------------------------------------------------------------------------
interface bsg_rr_arb_mux_buffer_w28_e2_if #(
  parameter int width_p = 28
);
  logic [2*width_p-1:0] data_i;
  logic [1:0]           v_i;
  logic [1:0]           yumi_o;
  logic [1:0]           sel_one_hot_o;
  logic [width_p-1:0]   data_o;
  logic                 tag_o;
  logic                 v_o;
  logic                 yumi_i;

  modport slave (
    input  data_i, v_i, yumi_i,
    output yumi_o, sel_one_hot_o, data_o, tag_o, v_o
  );

  modport master (
    output data_i, v_i, yumi_i,
    input  yumi_o, sel_one_hot_o, data_o, tag_o, v_o
  );
endinterface

// File: rtl/bsg_rr_arb_mux_buffer_w28_e2.sv
// ---------------------------------------------------------------------------
// bsg_rr_arb_mux_buffer_w28_e2
// Two-channel round-robin arbiter feeding a small FIFO of {tag, payload}.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-high reset (control state only)
//   bus     : handshake bundle (slave modport), see the interface file
// The winner of arbitration is muxed with a one-hot AND-OR mux and written
// into the FIFO; the FIFO head is presented unregistered from storage.
// ---------------------------------------------------------------------------

// Protocol checks for the buffer; kept out of the datapath module.
module bsg_rr_arb_mux_buffer_w28_e2_checker (
  input logic       clk_i,
  input logic       reset_i,
  input logic [1:0] v_i,
  input logic [1:0] yumi_o,
  input logic       v_o,
  input logic       yumi_i
);
  a_no_consume_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o));
  a_yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    (yumi_o & ~v_i) == 2'b00);
  a_yumi_one_hot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(yumi_o));
endmodule

module bsg_rr_arb_mux_buffer_w28_e2 #(
  parameter int width_p = 28,
  parameter int els_p   = 2
) (
  input logic                           clk_i,
  input logic                           reset_i,
  bsg_rr_arb_mux_buffer_w28_e2_if.slave bus
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  // Pointer increment with wrap at els_p-1 (depth need not be a power of two).
  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    if (p == last_ptr_lp) next_ptr = {ptr_w_lp{1'b0}};
    else                  next_ptr = p + ptr_w_lp'(1);
  endfunction

  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q,  count_d;
  logic                last_q,   last_d;
  logic [width_p:0]    mem_q [els_p];
  logic [width_p:0]    wr_entry_d;

  logic [1:0]          grant;
  logic [width_p-1:0]  word;
  logic                full;
  logic                not_empty;
  logic [1:0]          yumi;
  logic                enq;
  logic                deq;

  // Round-robin grant; last_q holds the channel of the most recent enqueue,
  // and reset forces the grant (and thus yumi_o) low asynchronously.
  always_comb begin
    grant = 2'b00;
    if (reset_i) begin
      grant = 2'b00;
    end else begin
      case (bus.v_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // One-hot AND-OR payload mux.
  always_comb begin
    word = {width_p{1'b0}};
    for (int i = 0; i < 2; i++) begin
      word = word | (bus.data_i[i*width_p +: width_p] & {width_p{grant[i]}});
    end
  end

  assign full       = (count_q == full_cnt_lp);
  assign not_empty  = (count_q != {cnt_w_lp{1'b0}});
  assign yumi       = grant & {2{~full}};
  assign enq        = |yumi;
  // Dequeue is gated by non-empty so an illegal yumi_i cannot corrupt state.
  assign deq        = bus.yumi_i & not_empty;
  assign wr_entry_d = {grant[1], word};

  // Next-state for pointers, occupancy and round-robin priority.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (enq) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
      last_d   = grant[1];
    end else begin
      wr_ptr_d = wr_ptr_q;
      last_d   = last_q;
    end
    if (deq) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; last_q resets to 1 so channel 0 wins first.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= {ptr_w_lp{1'b0}};
      rd_ptr_q <= {ptr_w_lp{1'b0}};
      count_q  <= {cnt_w_lp{1'b0}};
      last_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Payload storage; intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= wr_entry_d;
    end
  end

  assign bus.sel_one_hot_o = grant;
  assign bus.yumi_o        = yumi;
  assign bus.v_o           = not_empty;
  assign bus.data_o        = mem_q[rd_ptr_q][width_p-1:0];
  assign bus.tag_o         = mem_q[rd_ptr_q][width_p];

  bsg_rr_arb_mux_buffer_w28_e2_checker u_checker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (bus.v_i),
    .yumi_o  (yumi),
    .v_o     (not_empty),
    .yumi_i  (bus.yumi_i)
  );
endmodule

// File: tb/tb_bsg_rr_arb_mux_buffer_w28_e2.sv
// ---------------------------------------------------------------------------
// Testbench for bsg_rr_arb_mux_buffer_w28_e2: directed vector table, hand
// sequences for reset/wrap corners, and randomized traffic against a
// queue-based reference model.
// ---------------------------------------------------------------------------
module tb_bsg_rr_arb_mux_buffer_w28_e2;
  logic clk;
  logic reset_i;
  int   checks   = 0;
  int   failures = 0;

  bsg_rr_arb_mux_buffer_w28_e2_if #(.width_p(28)) bus2 ();
  bsg_rr_arb_mux_buffer_w28_e2_if #(.width_p(28)) bus3 ();

  bsg_rr_arb_mux_buffer_w28_e2 #(.width_p(28), .els_p(2)) dut2 (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus2)
  );

  bsg_rr_arb_mux_buffer_w28_e2 #(.width_p(28), .els_p(3)) dut3 (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [1:0]  v;
    logic [27:0] d0;
    logic [27:0] d1;
    logic        yi;
    logic [1:0]  e_sel;
    logic [1:0]  e_yumi;
    logic        e_v;
    logic [27:0] e_data;
    logic        e_tag;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus2.v_i = 2'b00; bus2.data_i = 56'h0; bus2.yumi_i = 1'b0;
    bus3.v_i = 2'b00; bus3.data_i = 56'h0; bus3.yumi_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // reference model state
  logic [28:0] q[$];
  bit          last_m;
  bit          p0, p1;
  logic [27:0] pd0, pd1;
  logic        yi;
  logic [1:0]  eg, ey;
  int          w;

  initial begin
    reset_i = 1'b1;
    idle_inputs();

    // Directed vectors: alternation, single-channel fill, full-FIFO priority hold.
    vecs[0]  = '{1'b1, 2'b11, 28'hAAA, 28'hBBB, 1'b0, 2'b01, 2'b01, 1'b0, 28'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 28'hAAA, 28'hBBB, 1'b1, 2'b10, 2'b10, 1'b1, 28'hAAA, 1'b0};
    vecs[2]  = '{1'b0, 2'b11, 28'hAAA, 28'hBBB, 1'b1, 2'b01, 2'b01, 1'b1, 28'hBBB, 1'b1};
    vecs[3]  = '{1'b0, 2'b11, 28'hAAA, 28'hBBB, 1'b1, 2'b10, 2'b10, 1'b1, 28'hAAA, 1'b0};
    vecs[4]  = '{1'b1, 2'b10, 28'h0, 28'hFFFFFFF, 1'b0, 2'b10, 2'b10, 1'b0, 28'h0, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 28'h0, 28'hFFFFFFF, 1'b0, 2'b10, 2'b10, 1'b1, 28'hFFFFFFF, 1'b1};
    vecs[6]  = '{1'b0, 2'b10, 28'h0, 28'hFFFFFFF, 1'b0, 2'b10, 2'b00, 1'b1, 28'hFFFFFFF, 1'b1};
    vecs[7]  = '{1'b0, 2'b10, 28'h0, 28'hFFFFFFF, 1'b0, 2'b10, 2'b00, 1'b1, 28'hFFFFFFF, 1'b1};
    vecs[8]  = '{1'b0, 2'b11, 28'h1111111, 28'h2222222, 1'b1, 2'b01, 2'b00, 1'b1, 28'hFFFFFFF, 1'b1};
    vecs[9]  = '{1'b0, 2'b11, 28'h1111111, 28'h2222222, 1'b0, 2'b01, 2'b01, 1'b1, 28'hFFFFFFF, 1'b1};
    vecs[10] = '{1'b0, 2'b11, 28'h1111111, 28'h2222222, 1'b1, 2'b10, 2'b00, 1'b1, 28'hFFFFFFF, 1'b1};
    vecs[11] = '{1'b0, 2'b11, 28'h1111111, 28'h2222222, 1'b1, 2'b10, 2'b10, 1'b1, 28'h1111111, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 28'h0, 28'h0, 1'b1, 2'b00, 2'b00, 1'b1, 28'h2222222, 1'b1};
    vecs[13] = '{1'b0, 2'b00, 28'h0, 28'h0, 1'b0, 2'b00, 2'b00, 1'b0, 28'h0, 1'b0};

    // Reset state
    do_reset();
    chk("reset_v_o", {31'h0, bus2.v_o}, 32'h0);
    chk("reset_yumi_o", {30'h0, bus2.yumi_o}, 32'h0);
    reset_i = 1'b1;
    #1;
    chk("in_reset_sel", {30'h0, bus2.sel_one_hot_o}, 32'h0);
    reset_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      bus2.v_i    = vecs[i].v;
      bus2.data_i = {vecs[i].d1, vecs[i].d0};
      bus2.yumi_i = vecs[i].yi;
      #1;
      chk($sformatf("vec%0d_sel", i), {30'h0, bus2.sel_one_hot_o}, {30'h0, vecs[i].e_sel});
      chk($sformatf("vec%0d_yumi", i), {30'h0, bus2.yumi_o}, {30'h0, vecs[i].e_yumi});
      chk($sformatf("vec%0d_v_o", i), {31'h0, bus2.v_o}, {31'h0, vecs[i].e_v});
      if (vecs[i].e_v) begin
        chk($sformatf("vec%0d_data", i), {4'h0, bus2.data_o}, {4'h0, vecs[i].e_data});
        chk($sformatf("vec%0d_tag", i), {31'h0, bus2.tag_o}, {31'h0, vecs[i].e_tag});
      end
      next_cycle();
    end

    // Asynchronous reset mid-burst with two words buffered.
    do_reset();
    bus2.v_i = 2'b10; bus2.data_i = {28'h3333333, 28'h0};
    next_cycle();
    next_cycle();
    bus2.v_i = 2'b11; bus2.data_i = {28'h3333333, 28'h4444444};
    #1;
    chk("pre_arst_v_o", {31'h0, bus2.v_o}, 32'h1);
    chk("pre_arst_sel", {30'h0, bus2.sel_one_hot_o}, 32'h1);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_v_o", {31'h0, bus2.v_o}, 32'h0);
    chk("arst_yumi", {30'h0, bus2.yumi_o}, 32'h0);
    chk("arst_sel", {30'h0, bus2.sel_one_hot_o}, 32'h0);
    @(posedge clk);
    #1 reset_i = 1'b0;
    #1;
    chk("post_arst_yumi", {30'h0, bus2.yumi_o}, 32'h1);
    chk("post_arst_v_o", {31'h0, bus2.v_o}, 32'h0);
    next_cycle();
    chk("post_arst_head", {4'h0, bus2.data_o}, 32'h4444444);
    chk("post_arst_tag", {31'h0, bus2.tag_o}, 32'h0);

    // Randomized traffic against the queue model (depth 2).
    do_reset();
    q.delete();
    last_m = 1'b1;
    p0 = 1'b0; p1 = 1'b0; pd0 = 28'h0; pd1 = 28'h0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (!p0 && (cyc % 2 == 0) && ($urandom_range(0, 1) == 1)) begin
        p0 = 1'b1; pd0 = 28'($urandom);
      end
      if (!p1 && ($urandom_range(0, 2) != 0)) begin
        p1 = 1'b1; pd1 = 28'($urandom);
      end
      yi = (q.size() != 0) && ($urandom_range(0, 1) == 1);
      bus2.v_i    = {p1, p0};
      bus2.data_i = {pd1, pd0};
      bus2.yumi_i = yi;
      #1;
      // Winner: sole requester, or the channel other than the last one enqueued.
      if (!p0 && !p1) w = -1;
      else if (p0 && p1) w = (last_m == 1'b0) ? 1 : 0;
      else w = p1 ? 1 : 0;
      eg = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
      ey = (q.size() == 2) ? 2'b00 : eg;
      chk("rnd_sel", {30'h0, bus2.sel_one_hot_o}, {30'h0, eg});
      chk("rnd_yumi", {30'h0, bus2.yumi_o}, {30'h0, ey});
      chk("rnd_v_o", {31'h0, bus2.v_o}, {31'h0, q.size() != 0});
      if (q.size() != 0) begin
        chk("rnd_data", {4'h0, bus2.data_o}, {4'h0, q[0][27:0]});
        chk("rnd_tag", {31'h0, bus2.tag_o}, {31'h0, q[0][28]});
      end
      // Producers react to the accept the DUT actually gave.
      if (bus2.yumi_o[0]) p0 = 1'b0;
      if (bus2.yumi_o[1]) p1 = 1'b0;
      next_cycle();
      if (yi) void'(q.pop_front());
      if (ey != 2'b00) begin
        q.push_back({w[0], (w == 1) ? bus2.data_i[55:28] : bus2.data_i[27:0]});
        last_m = w[0];
      end
    end

    // Depth-3 build: fill, drain, refill, drain across the pointer wrap.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 3; k++) begin
        bus3.v_i = 2'b01;
        bus3.data_i = {28'h0, 28'(r * 3 + k)};
        bus3.yumi_i = 1'b0;
        #1;
        chk($sformatf("e3_fill_yumi_r%0d_k%0d", r, k), {30'h0, bus3.yumi_o}, 32'h1);
        next_cycle();
      end
      bus3.data_i = {28'h0, 28'h7};
      #1;
      chk($sformatf("e3_full_yumi_r%0d", r), {30'h0, bus3.yumi_o}, 32'h0);
      chk($sformatf("e3_full_v_o_r%0d", r), {31'h0, bus3.v_o}, 32'h1);
      bus3.v_i = 2'b00;
      for (int k = 1; k <= 3; k++) begin
        bus3.yumi_i = 1'b1;
        #1;
        chk($sformatf("e3_drain_data_r%0d_k%0d", r, k), {4'h0, bus3.data_o}, 32'(r * 3 + k));
        chk($sformatf("e3_drain_tag_r%0d_k%0d", r, k), {31'h0, bus3.tag_o}, 32'h0);
        next_cycle();
      end
      bus3.yumi_i = 1'b0;
      #1;
      chk($sformatf("e3_empty_v_o_r%0d", r), {31'h0, bus3.v_o}, 32'h0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
